// File: rtl/sram_responder_pkg.sv
// Shared constants and helpers for the SRAM responder: register window base,
// register offsets and the byte-lane merge used by every writable word.
package sram_responder_pkg;

    localparam logic [15:0] CONF_BASE_DEFAULT = 16'hBFAF;

    localparam logic [15:0] TIMER_OFF   = 16'hE000;
    localparam logic [15:0] COMPARE_OFF = 16'hE004;
    localparam logic [15:0] LED_OFF     = 16'hF000;

    // Lane i of the result comes from new_word when lanes[i] is set.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  lanes);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/sram_resp_confreg.sv
// Register window: free-running TIMER, COMPARE with sticky interrupt, LED
// register. Read data is combinational and reflects pre-update values.
module sram_resp_confreg
    import sram_responder_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        sel,
    input  logic [3:0]  wen,
    input  logic [15:0] offset,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [15:0] led,
    output logic        timer_int
);

    logic [31:0] timer;
    logic [31:0] compare;
    logic [15:0] led_reg;
    logic        wr;
    logic        timer_wr;
    logic        compare_wr;
    logic        led_wr;

    assign wr         = sel && (wen != 4'b0000);
    assign timer_wr   = wr && (offset == TIMER_OFF);
    assign compare_wr = wr && (offset == COMPARE_OFF);
    assign led_wr     = wr && (offset == LED_OFF);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            timer     <= 32'h0;
            compare   <= 32'h0;
            led_reg   <= 16'h0;
            timer_int <= 1'b0;
        end else begin
            // A TIMER write replaces this cycle's increment.
            if (timer_wr) begin
                timer <= merge_lanes(timer, wdata, wen);
            end else begin
                timer <= timer + 32'd1;
            end

            if (compare_wr) begin
                compare <= merge_lanes(compare, wdata, wen);
            end

            if (led_wr) begin
                if (wen[0]) led_reg[7:0]  <= wdata[7:0];
                if (wen[1]) led_reg[15:8] <= wdata[15:8];
            end

            // Clearing through a COMPARE write has priority over a match.
            if (compare_wr) begin
                timer_int <= 1'b0;
            end else if ((timer == compare) && (compare != 32'h0)) begin
                timer_int <= 1'b1;
            end
        end
    end

    always_comb begin
        rdata = 32'h0;
        case (offset)
            TIMER_OFF:   rdata = timer;
            COMPARE_OFF: rdata = compare;
            LED_OFF:     rdata = {16'h0, led_reg};
            default:     rdata = 32'h0;
        endcase
    end

    assign led = led_reg;

endmodule

// File: rtl/sram_responder.sv
// Single-cycle SRAM-style slave: byte-enabled word memory plus a memory-mapped
// register window. Accepts one access per cycle, read data one cycle later.
module sram_responder
    import sram_responder_pkg::*;
#(
    parameter int          ADDR_W    = 10,
    parameter logic [15:0] CONF_BASE = CONF_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        sram_en,
    input  logic [3:0]  sram_wen,
    input  logic [31:0] sram_addr,
    input  logic [31:0] sram_wdata,
    output logic [31:0] sram_rdata,
    output logic [15:0] led,
    output logic        timer_int
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0]       mem [DEPTH];
    logic              is_conf;
    logic              is_write;
    logic              is_read;
    logic [ADDR_W-1:0] word;
    logic [31:0]       conf_rdata;
    logic              unused_addr;

    assign is_conf  = (sram_addr[31:16] == CONF_BASE);
    assign is_write = sram_en && (sram_wen != 4'b0000);
    assign is_read  = sram_en && (sram_wen == 4'b0000);
    // Address bits above the array depth are dropped, so the memory aliases.
    assign word     = sram_addr[ADDR_W+1:2];
    assign unused_addr = ^sram_addr[1:0];

    sram_resp_confreg u_confreg (
        .clk       (clk),
        .resetn    (resetn),
        .sel       (sram_en && is_conf),
        .wen       (sram_wen),
        .offset    (sram_addr[15:0]),
        .wdata     (sram_wdata),
        .rdata     (conf_rdata),
        .led       (led),
        .timer_int (timer_int)
    );

    // Array contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (is_write && !is_conf) begin
            for (int i = 0; i < 4; i++) begin
                if (sram_wen[i]) begin
                    mem[word][8*i +: 8] <= sram_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sram_rdata <= 32'h0;
        end else if (is_read) begin
            sram_rdata <= is_conf ? conf_rdata : mem[word];
        end
    end

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: memory, aliasing, byte lanes, timer,
// interrupt, LED window and asynchronous reset behaviour.
module tb_sram_responder;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        sram_en = 1'b0;
    logic [3:0]  sram_wen = 4'h0;
    logic [31:0] sram_addr = 32'h0;
    logic [31:0] sram_wdata = 32'h0;
    logic [31:0] sram_rdata;
    logic [15:0] led;
    logic        timer_int;

    int checks = 0;
    int failures = 0;

    localparam logic [31:0] A_TIMER   = 32'hBFAFE000;
    localparam logic [31:0] A_COMPARE = 32'hBFAFE004;
    localparam logic [31:0] A_LED     = 32'hBFAFF000;

    // Clock and reset
    always #5 clk = ~clk;

    sram_responder #(.ADDR_W(10)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .sram_en    (sram_en),
        .sram_wen   (sram_wen),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .led        (led),
        .timer_int  (timer_int)
    );

    // Driver: present one access, then return 1ns after the capturing edge.
    task automatic cyc(input logic en, input logic [3:0] wen,
                       input logic [31:0] addr, input logic [31:0] wdata);
        sram_en    = en;
        sram_wen   = wen;
        sram_addr  = addr;
        sram_wdata = wdata;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #12;
        checks++;
        if (sram_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=%h", sram_rdata, 32'h0); end
        checks++;
        if (led !== 16'h0) begin failures++; $display("FAIL reset_led got=%h exp=%h", led, 16'h0); end
        checks++;
        if (timer_int !== 1'b0) begin failures++; $display("FAIL reset_int got=%b exp=0", timer_int); end
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic test_mem_rw();
        cyc(1'b1, 4'hF, 32'h0000_0000, 32'hCAFEF00D);
        cyc(1'b1, 4'hF, 32'h0000_0010, 32'h12345678);
        cyc(1'b1, 4'h0, 32'h0000_0010, 32'h0);
        checks++;
        if (sram_rdata !== 32'h12345678) begin failures++; $display("FAIL mem_read got=%h exp=%h", sram_rdata, 32'h12345678); end
    endtask

    task automatic test_alias_merge();
        cyc(1'b1, 4'b0101, 32'h0000_0010, 32'hAABBCCDD);
        cyc(1'b1, 4'h0, 32'h0000_0010, 32'h0);
        checks++;
        if (sram_rdata !== 32'h12BB56DD) begin failures++; $display("FAIL lane_merge got=%h exp=%h", sram_rdata, 32'h12BB56DD); end
        cyc(1'b1, 4'h0, 32'h0000_1010, 32'h0);
        checks++;
        if (sram_rdata !== 32'h12BB56DD) begin failures++; $display("FAIL alias_read got=%h exp=%h", sram_rdata, 32'h12BB56DD); end
    endtask

    task automatic test_hold();
        idle();
        checks++;
        if (sram_rdata !== 32'h12BB56DD) begin failures++; $display("FAIL hold_idle got=%h exp=%h", sram_rdata, 32'h12BB56DD); end
        cyc(1'b1, 4'hF, 32'h0000_0020, 32'hDEADBEEF);
        checks++;
        if (sram_rdata !== 32'h12BB56DD) begin failures++; $display("FAIL hold_write got=%h exp=%h", sram_rdata, 32'h12BB56DD); end
        cyc(1'b1, 4'h0, 32'h0000_0020, 32'h0);
        checks++;
        if (sram_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL back_to_back got=%h exp=%h", sram_rdata, 32'hDEADBEEF); end
    endtask

    task automatic test_timer_wrap();
        cyc(1'b1, 4'hF, A_TIMER, 32'hFFFFFFFE);
        cyc(1'b1, 4'h0, A_TIMER, 32'h0);
        checks++;
        if (sram_rdata !== 32'hFFFFFFFE) begin failures++; $display("FAIL timer_load got=%h exp=%h", sram_rdata, 32'hFFFFFFFE); end
        cyc(1'b1, 4'h0, A_TIMER, 32'h0);
        checks++;
        if (sram_rdata !== 32'hFFFFFFFF) begin failures++; $display("FAIL timer_inc got=%h exp=%h", sram_rdata, 32'hFFFFFFFF); end
        cyc(1'b1, 4'h0, A_TIMER, 32'h0);
        checks++;
        if (sram_rdata !== 32'h00000000) begin failures++; $display("FAIL timer_wrap got=%h exp=%h", sram_rdata, 32'h0); end
    endtask

    task automatic test_timer_int();
        logic [31:0] exp_t;
        logic        exp_i;
        cyc(1'b1, 4'hF, A_COMPARE, 32'd100);
        cyc(1'b1, 4'hF, A_TIMER, 32'd90);
        checks++;
        if (timer_int !== 1'b0) begin failures++; $display("FAIL int_pre got=%b exp=0", timer_int); end
        // Read k sees TIMER=89+k; the edge that reads 100 also raises the interrupt.
        for (int k = 1; k <= 11; k++) begin
            cyc(1'b1, 4'h0, A_TIMER, 32'h0);
            exp_t = 32'd89 + 32'(k);
            exp_i = (k == 11);
            checks++;
            if (sram_rdata !== exp_t) begin failures++; $display("FAIL int_timer k=%0d got=%h exp=%h", k, sram_rdata, exp_t); end
            checks++;
            if (timer_int !== exp_i) begin failures++; $display("FAIL int_rise k=%0d got=%b exp=%b", k, timer_int, exp_i); end
        end
        idle();
        checks++;
        if (timer_int !== 1'b1) begin failures++; $display("FAIL int_sticky got=%b exp=1", timer_int); end
        cyc(1'b1, 4'hF, A_COMPARE, 32'd0);
        checks++;
        if (timer_int !== 1'b0) begin failures++; $display("FAIL int_clear got=%b exp=0", timer_int); end
    endtask

    task automatic test_led_window();
        cyc(1'b1, 4'hF, A_LED, 32'hFFFF1234);
        checks++;
        if (led !== 16'h1234) begin failures++; $display("FAIL led_out got=%h exp=%h", led, 16'h1234); end
        cyc(1'b1, 4'h0, A_LED, 32'h0);
        checks++;
        if (sram_rdata !== 32'h00001234) begin failures++; $display("FAIL led_read got=%h exp=%h", sram_rdata, 32'h00001234); end
        cyc(1'b1, 4'b0010, A_LED, 32'h0000AB00);
        checks++;
        if (led !== 16'hAB34) begin failures++; $display("FAIL led_lane got=%h exp=%h", led, 16'hAB34); end
        cyc(1'b1, 4'hF, 32'hBFAF0004, 32'h55555555);
        cyc(1'b1, 4'h0, 32'hBFAF0004, 32'h0);
        checks++;
        if (sram_rdata !== 32'h0) begin failures++; $display("FAIL undecoded got=%h exp=%h", sram_rdata, 32'h0); end
        // Window offset F000 maps onto memory word 0, which must be untouched.
        cyc(1'b1, 4'h0, 32'h0000_0000, 32'h0);
        checks++;
        if (sram_rdata !== 32'hCAFEF00D) begin failures++; $display("FAIL mem_isolated got=%h exp=%h", sram_rdata, 32'hCAFEF00D); end
    endtask

    task automatic test_reset_mid_burst();
        cyc(1'b1, 4'hF, A_COMPARE, 32'd50);
        cyc(1'b1, 4'hF, A_TIMER, 32'd50);
        idle();
        checks++;
        if (timer_int !== 1'b1) begin failures++; $display("FAIL int_before_rst got=%b exp=1", timer_int); end
        cyc(1'b1, 4'h0, 32'h0000_0010, 32'h0);
        cyc(1'b1, 4'h0, 32'h0000_0020, 32'h0);
        checks++;
        if (sram_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL burst_read got=%h exp=%h", sram_rdata, 32'hDEADBEEF); end
        sram_en   = 1'b1;
        sram_wen  = 4'h0;
        sram_addr = 32'h0000_0010;
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (sram_rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=%h", sram_rdata, 32'h0); end
        checks++;
        if (led !== 16'h0) begin failures++; $display("FAIL rst_led got=%h exp=%h", led, 16'h0); end
        checks++;
        if (timer_int !== 1'b0) begin failures++; $display("FAIL rst_int got=%b exp=0", timer_int); end
        @(posedge clk);
        #1;
        checks++;
        if (sram_rdata !== 32'h0) begin failures++; $display("FAIL rst_discard got=%h exp=%h", sram_rdata, 32'h0); end
        resetn = 1'b1;
        cyc(1'b1, 4'h0, A_TIMER, 32'h0);
        checks++;
        if (sram_rdata !== 32'h0) begin failures++; $display("FAIL rst_timer got=%h exp=%h", sram_rdata, 32'h0); end
        cyc(1'b1, 4'h0, 32'h0000_0010, 32'h0);
        checks++;
        if (sram_rdata !== 32'h12BB56DD) begin failures++; $display("FAIL mem_retained got=%h exp=%h", sram_rdata, 32'h12BB56DD); end
        cyc(1'b1, 4'h0, A_COMPARE, 32'h0);
        checks++;
        if (sram_rdata !== 32'h0) begin failures++; $display("FAIL rst_compare got=%h exp=%h", sram_rdata, 32'h0); end
        idle();
    endtask

    initial begin
        test_reset();
        test_mem_rw();
        test_alias_merge();
        test_hold();
        test_timer_wrap();
        test_timer_int();
        test_led_window();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
